// File: rtl/router_pkg.sv
// Shared mesh-router definitions: coordinate type, packet types, header field
// offsets and the mask-bit to coordinate mapping.
package router_pkg;

    typedef logic [1:0] coord_t;

    typedef enum logic [1:0] {
        PKT_SPIKE  = 2'b00,
        PKT_WEIGHT = 2'b01,
        PKT_PSUM   = 2'b10,
        PKT_CTRL   = 2'b11
    } pkt_type_e;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } coord_pair_t;

    // Offsets of each 2-bit field's MSB, counted down from the packet MSB.
    localparam int XSRC_HI = 0;
    localparam int YSRC_HI = 2;
    localparam int XDST_HI = 4;
    localparam int YDST_HI = 6;
    localparam int TYPE_HI = 8;

    function automatic coord_pair_t mask_to_coord(input logic [3:0] idx);
        coord_pair_t c;
        c.x = idx[1:0];
        c.y = idx[3:2];
        return c;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock descriptor FIFO; push ignored when full, pop ignored when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only, so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pe_packet_injector.sv
// PE-to-router injection stage: buffers multicast descriptors and serialises each
// into unicast mesh packets, lowest destination index first, never to itself.
module pe_packet_injector
    import router_pkg::*;
#(
    parameter int WIDTH      = 31,
    parameter int XADDR      = 0,
    parameter int YADDR      = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_mask,
    input  logic [1:0]        in_type,
    input  logic [WIDTH-11:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_packet,
    output logic              busy,
    output logic [7:0]        err_cnt
);

    localparam int DATA_W = WIDTH - 10;
    localparam int DESC_W = 16 + 2 + DATA_W;
    localparam coord_t SELF_X = coord_t'(XADDR);
    localparam coord_t SELF_Y = coord_t'(YADDR);
    localparam logic [15:0] SELF_BIT = 16'd1 << {SELF_Y, SELF_X};

    typedef enum logic {ST_IDLE, ST_SEND} state_e;

    state_e              state_q, state_d;
    logic [15:0]         mask_q, mask_d;
    logic [1:0]          type_q, type_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [WIDTH-1:0]    packet_d;
    coord_pair_t         dst;
    logic                err_inc;

    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DESC_W-1:0]   fifo_dout;
    logic [15:0]         desc_mask;
    logic [1:0]          desc_type;
    logic [DATA_W-1:0]   desc_data;

    function automatic logic [3:0] lowest_idx(input logic [15:0] m);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    assign fifo_push = in_valid && in_ready;
    assign {desc_mask, desc_type, desc_data} = fifo_dout;

    sync_fifo #(
        .WIDTH (DESC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   ({in_mask, in_type, in_data}),
        .full  (fifo_full),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mask_q     <= '0;
            out_packet <= '0;
            err_cnt    <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            if (state_d == ST_SEND) out_packet <= packet_d;
            if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_pop) begin
            type_q <= desc_type;
            data_q <= desc_data;
        end
    end

    // mask_d is the set of destinations still owed after this edge; the next
    // packet is always built from its lowest set bit.
    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        type_d   = type_q;
        data_d   = data_q;
        fifo_pop = 1'b0;
        err_inc  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    mask_d   = desc_mask & ~SELF_BIT;
                    type_d   = desc_type;
                    data_d   = desc_data;
                    if (mask_d == '0) err_inc = 1'b1;
                    else              state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    mask_d = mask_q & (mask_q - 16'd1);
                    if (mask_d == '0) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        dst      = mask_to_coord(lowest_idx(mask_d));
        packet_d = '0;
        packet_d[WIDTH-1-XSRC_HI -: 2] = SELF_X;
        packet_d[WIDTH-1-YSRC_HI -: 2] = SELF_Y;
        packet_d[WIDTH-1-XDST_HI -: 2] = dst.x;
        packet_d[WIDTH-1-YDST_HI -: 2] = dst.y;
        packet_d[WIDTH-1-TYPE_HI -: 2] = type_d;
        packet_d[DATA_W-1:0]           = data_d;
    end

    always_comb begin
        out_valid = (state_q == ST_SEND);
        in_ready  = !fifo_full;
        busy      = !fifo_empty || (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_pe_packet_injector.sv
// Scoreboard bench for pe_packet_injector at node (0,0).
module tb_pe_packet_injector;

    localparam int WIDTH  = 31;
    localparam int DATA_W = WIDTH - 10;
    localparam int XADDR  = 0;
    localparam int YADDR  = 0;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_mask;
    logic [1:0]        in_type;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_packet;
    logic              busy;
    logic [7:0]        err_cnt;

    int               checks = 0;
    int               passed = 0;
    int               hs_cnt = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_pkt = '0;
    logic             acc = 1'b0;

    always #5 clk = ~clk;

    pe_packet_injector #(
        .WIDTH      (WIDTH),
        .XADDR      (XADDR),
        .YADDR      (YADDR),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mask    (in_mask),
        .in_type    (in_type),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_packet (out_packet),
        .busy       (busy),
        .err_cnt    (err_cnt)
    );

    function automatic logic [WIDTH-1:0] exp_pkt(input int idx, input logic [1:0] t,
                                                 input logic [DATA_W-1:0] d);
        logic [3:0] i4;
        i4 = 4'(idx);
        return {2'(XADDR), 2'(YADDR), i4[1:0], i4[3:2], t, d};
    endfunction

    task automatic push_expected(input logic [15:0] m, input logic [1:0] t,
                                 input logic [DATA_W-1:0] d);
        for (int i = 0; i < 16; i++) begin
            if (m[i] && i != YADDR * 4 + XADDR) exp_q.push_back(exp_pkt(i, t, d));
        end
    endtask

    // One clock: sample at the falling edge, let the rising edge happen, return 1ns after it.
    task automatic tick();
        logic [WIDTH-1:0] exp;
        @(negedge clk);
        if (rst_n && prev_stall) begin
            checks++;
            if (out_valid !== 1'b1 || out_packet !== prev_pkt)
                $display("FAIL hold: out_valid=%b out_packet=%h, required 1 / %h",
                         out_valid, out_packet, prev_pkt);
            else passed++;
        end
        prev_stall = rst_n && out_valid && !out_ready;
        prev_pkt   = out_packet;
        acc        = rst_n && in_valid && in_ready;
        if (acc) push_expected(in_mask, in_type, in_data);
        if (rst_n && out_valid && out_ready) begin
            hs_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL packet: got unexpected %h, required no packet", out_packet);
            end else begin
                exp = exp_q.pop_front();
                if (out_packet !== exp)
                    $display("FAIL packet: got %h, required %h", out_packet, exp);
                else passed++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_desc(input logic [15:0] m, input logic [1:0] t,
                             input logic [DATA_W-1:0] d);
        in_valid = 1'b1;
        in_mask  = m;
        in_type  = t;
        in_data  = d;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (acc) break;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            $display("FAIL accept: mask %h not accepted, required acceptance within 200 cycles", m);
        end
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 500 && busy; c++) tick();
        checks++;
        if (busy !== 1'b0) $display("FAIL idle: busy=%b after 500 cycles, required 0", busy);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mask   = '0;
        in_type   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: %b, required 0", out_valid); else passed++;
        checks++; if (out_packet !== '0) $display("FAIL rst_out_packet: %h, required 0", out_packet); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: %b, required 1", in_ready); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy: %b, required 0", busy); else passed++;
        checks++; if (err_cnt !== 8'd0) $display("FAIL rst_err_cnt: %0d, required 0", err_cnt); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        send_desc(16'h0002, 2'b00, 21'd5);
        checks++; if (out_valid !== 1'b0) $display("FAIL single_early: out_valid=%b, required 0", out_valid); else passed++;
        tick();
        checks++; if (out_valid !== 1'b1) $display("FAIL single_valid: out_valid=%b, required 1", out_valid); else passed++;
        checks++;
        if (out_packet !== {8'b0000_0100, 2'b00, 21'd5})
            $display("FAIL single_packet: %h, required %h", out_packet, {8'b0000_0100, 2'b00, 21'd5});
        else passed++;
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL single_done: out_valid=%b, required 0", out_valid); else passed++;
    endtask

    task automatic test_multicast();
        int h0;
        h0 = hs_cnt;
        out_ready = 1'b1;
        send_desc(16'h8421, 2'b01, 21'h12345);
        tick();
        checks++;
        if (out_packet[26:23] !== 4'b0101) $display("FAIL mc_first_dest: %b, required 0101", out_packet[26:23]);
        else passed++;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (hs_cnt - h0 !== k) $display("FAIL mc_consecutive: %0d packets, required %0d", hs_cnt - h0, k);
            else passed++;
        end
        checks++; if (out_valid !== 1'b0) $display("FAIL mc_end: out_valid=%b, required 0", out_valid); else passed++;
        checks++; if (exp_q.size() != 0) $display("FAIL mc_drain: %0d pending, required 0", exp_q.size()); else passed++;
    endtask

    task automatic test_errors();
        int h0;
        h0 = hs_cnt;
        send_desc(16'h0001, 2'b11, 21'h1);
        send_desc(16'h0000, 2'b10, 21'h2);
        wait_idle();
        checks++; if (err_cnt !== 8'd2) $display("FAIL err_cnt: %0d, required 2", err_cnt); else passed++;
        checks++; if (hs_cnt != h0) $display("FAIL err_packets: %0d, required 0", hs_cnt - h0); else passed++;
    endtask

    task automatic test_backpressure();
        logic [15:0]      masks [5];
        logic [WIDTH-1:0] held;
        masks = '{16'h0010, 16'h0300, 16'h8001, 16'h00F0, 16'h0F00};
        out_ready = 1'b0;
        send_desc(16'h0006, 2'b10, 21'h0ABCD);
        tick();
        checks++; if (out_valid !== 1'b1) $display("FAIL bp_valid: %b, required 1", out_valid); else passed++;
        checks++;
        if (out_packet !== {8'b0000_0100, 2'b10, 21'h0ABCD})
            $display("FAIL bp_packet: %h, required %h", out_packet, {8'b0000_0100, 2'b10, 21'h0ABCD});
        else passed++;
        held = out_packet;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c < 5);
            if (c < 5) begin
                in_mask = masks[c];
                in_type = 2'(c);
                in_data = DATA_W'(c * 7 + 1);
            end
            if (c == 4) begin
                checks++; if (in_ready !== 1'b0) $display("FAIL bp_full: in_ready=%b, required 0", in_ready); else passed++;
            end
            tick();
            if (c < 4) begin
                checks++; if (acc !== 1'b1) $display("FAIL bp_accept%0d: %b, required 1", c, acc); else passed++;
            end
            if (c == 4) begin
                checks++; if (acc !== 1'b0) $display("FAIL bp_reject: %b, required 0", acc); else passed++;
            end
            checks++;
            if (out_valid !== 1'b1 || out_packet !== held)
                $display("FAIL bp_stable: %b/%h, required 1/%h", out_valid, out_packet, held);
            else passed++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        checks++; if (exp_q.size() != 0) $display("FAIL bp_drain: %0d pending, required 0", exp_q.size()); else passed++;
    endtask

    task automatic test_reset_mid();
        int h0;
        out_ready = 1'b0;
        h0 = hs_cnt;
        send_desc(16'h001E, 2'b11, 21'h1F00F);
        send_desc(16'h0C00, 2'b00, 21'h7);
        out_ready = 1'b1;
        tick();
        tick();
        checks++; if (hs_cnt - h0 != 2) $display("FAIL rm_sent: %0d, required 2", hs_cnt - h0); else passed++;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL rm_out_valid: %b, required 0", out_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rm_busy: %b, required 0", busy); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL rm_in_ready: %b, required 1", in_ready); else passed++;
        checks++; if (out_packet !== '0) $display("FAIL rm_packet: %h, required 0", out_packet); else passed++;
        checks++; if (exp_q.size() != 4) $display("FAIL rm_pending: %0d, required 4", exp_q.size()); else passed++;
        exp_q.delete();
        tick();
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        h0 = hs_cnt;
        repeat (10) tick();
        checks++; if (hs_cnt != h0) $display("FAIL rm_residual: %0d packets, required 0", hs_cnt - h0); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL rm_idle: out_valid=%b, required 0", out_valid); else passed++;
    endtask

    task automatic test_random();
        logic [15:0] self_bit;
        logic [15:0] m;
        int          errs;
        int          total;
        int          h0;
        int          r;
        self_bit = 16'd1 << (YADDR * 4 + XADDR);
        errs  = 0;
        total = 0;
        h0    = hs_cnt;
        for (int n = 0; n < 40; n++) begin
            m = 16'($urandom);
            r = $urandom_range(0, 7);
            if (r == 0) m = 16'h0000;
            if (r == 1) m = self_bit;
            if ((m & ~self_bit) == '0) errs++;
            total += $countones(m & ~self_bit);
            in_valid = 1'b1;
            in_mask  = m;
            in_type  = 2'($urandom);
            in_data  = DATA_W'($urandom);
            for (int c = 0; c < 300; c++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                tick();
                if (acc) break;
            end
            in_valid = 1'b0;
            if (!acc) begin
                checks++;
                $display("FAIL rnd_accept: descriptor %0d not accepted, required acceptance within 300 cycles", n);
            end
        end
        out_ready = 1'b1;
        wait_idle();
        checks++; if (exp_q.size() != 0) $display("FAIL rnd_drain: %0d pending, required 0", exp_q.size()); else passed++;
        checks++; if (hs_cnt - h0 != total) $display("FAIL rnd_count: %0d packets, required %0d", hs_cnt - h0, total); else passed++;
        checks++; if (err_cnt !== 8'(errs)) $display("FAIL rnd_err_cnt: %0d, required %0d", err_cnt, errs); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_multicast();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
